// File: rtl/dds_pkg.sv
// Shared constants and types for the DDS sweep controller and the CORDIC DDS core.
package dds_pkg;

    localparam int QUAN_BIT = 14;
    localparam int MAX_INC  = 2047;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DWELL = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/dds_step_gen.sv
// Next phase-increment for a linear sweep, clamped so it never passes the stop value.
module dds_step_gen #(
    parameter int W = 14
) (
    input  logic [W-1:0] cur,
    input  logic [W-1:0] stop,
    input  logic [W-1:0] delta,
    input  logic         dir,
    output logic [W-1:0] next,
    output logic         last
);
    import dds_pkg::*;

    logic [W:0] cur_x;
    logic [W:0] stop_x;
    logic [W:0] delta_x;
    logic [W:0] up_sum;
    logic [W:0] dn_floor;

    // One extra bit keeps cur+delta and stop+delta from wrapping.
    always_comb begin
        cur_x    = {1'b0, cur};
        stop_x   = {1'b0, stop};
        delta_x  = {1'b0, delta};
        up_sum   = cur_x + delta_x;
        dn_floor = stop_x + delta_x;
        next     = cur;
        if (dir == DIR_UP) begin
            if (up_sum >= stop_x) next = stop;
            else                  next = up_sum[W-1:0];
        end else begin
            if (cur_x <= dn_floor) next = stop;
            else                   next = cur - delta;
        end
        // A zero step can never reach stop, so it ends the sweep after one value.
        last = (cur == stop) || (delta == '0);
    end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Linear phase-increment sweep sequencer feeding the CORDIC DDS core.
// Define SWEEP_LOOP_EN to restart from the start increment instead of finishing.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for I_start; outputs hold last increment/phase
// ST_LOAD  | change-phase pulse, start increment applied, first dwell cycle
// ST_DWELL | holding the current increment until the dwell counter expires
// ST_DONE  | one-cycle O_done pulse, then back to idle
module dds_sweep_ctrl #(
    parameter int QUAN_BIT = dds_pkg::QUAN_BIT,
    parameter int DWELL_W  = 16,
    parameter int IDX_W    = 12,
    parameter int MAX_INC  = dds_pkg::MAX_INC
) (
    input  logic                I_clk,
    input  logic                I_rst,
    input  logic                I_start,
    input  logic                I_abort,
    input  logic [QUAN_BIT-1:0] I_init_phase,
    input  logic [QUAN_BIT-1:0] I_start_inc,
    input  logic [QUAN_BIT-1:0] I_stop_inc,
    input  logic [QUAN_BIT-1:0] I_delta_inc,
    input  logic [DWELL_W-1:0]  I_dwell,
    output logic [QUAN_BIT-1:0] O_init_phase,
    output logic                O_change_phase,
    output logic [QUAN_BIT-1:0] O_inc_phase,
    output logic                O_busy,
    output logic                O_done,
    output logic [IDX_W-1:0]    O_step_idx
);
    import dds_pkg::*;

    localparam logic [QUAN_BIT-1:0] MAX_INC_W = QUAN_BIT'(MAX_INC);

    state_t               state;
    logic [QUAN_BIT-1:0]  stop_q;
    logic [QUAN_BIT-1:0]  delta_q;
    logic [QUAN_BIT-1:0]  inc_q;
    logic [QUAN_BIT-1:0]  init_q;
    logic                 dir_q;
    logic [DWELL_W-1:0]   dwell_rld_q;
    logic [DWELL_W-1:0]   dwell_cnt_q;
    logic [IDX_W-1:0]     idx_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 change_q;
`ifdef SWEEP_LOOP_EN
    logic [QUAN_BIT-1:0]  start_q;
`endif

    logic [QUAN_BIT-1:0]  start_sat;
    logic [QUAN_BIT-1:0]  stop_sat;
    logic [DWELL_W-1:0]   dwell_m1;
    logic [QUAN_BIT-1:0]  step_next;
    logic                 step_last;

    always_comb begin
        start_sat = (I_start_inc > MAX_INC_W) ? MAX_INC_W : I_start_inc;
        stop_sat  = (I_stop_inc  > MAX_INC_W) ? MAX_INC_W : I_stop_inc;
        // Dwell counter runs D-1 down to 0; a dwell of 0 behaves like 1.
        dwell_m1  = (I_dwell == '0) ? '0 : I_dwell - 1'b1;
    end

    dds_step_gen #(
        .W (QUAN_BIT)
    ) u_step_gen (
        .cur   (inc_q),
        .stop  (stop_q),
        .delta (delta_q),
        .dir   (dir_q),
        .next  (step_next),
        .last  (step_last)
    );

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state       <= ST_IDLE;
            stop_q      <= '0;
            delta_q     <= '0;
            inc_q       <= '0;
            init_q      <= '0;
            dir_q       <= DIR_UP;
            dwell_rld_q <= '0;
            dwell_cnt_q <= '0;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            change_q    <= 1'b0;
`ifdef SWEEP_LOOP_EN
            start_q     <= '0;
`endif
        end else begin
            change_q <= 1'b0;
            done_q   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (I_start && !I_abort) begin
                        stop_q      <= stop_sat;
                        delta_q     <= I_delta_inc;
                        dir_q       <= (stop_sat >= start_sat) ? DIR_UP : DIR_DN;
                        dwell_rld_q <= dwell_m1;
                        dwell_cnt_q <= dwell_m1;
                        init_q      <= I_init_phase;
                        inc_q       <= start_sat;
                        idx_q       <= '0;
                        busy_q      <= 1'b1;
                        change_q    <= 1'b1;
`ifdef SWEEP_LOOP_EN
                        start_q     <= start_sat;
`endif
                        state       <= ST_LOAD;
                    end
                end
                ST_LOAD, ST_DWELL: begin
                    if (I_abort) begin
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end else if (dwell_cnt_q == '0) begin
                        if (step_last) begin
`ifdef SWEEP_LOOP_EN
                            inc_q       <= start_q;
                            idx_q       <= '0;
                            change_q    <= 1'b1;
                            done_q      <= 1'b1;
                            dwell_cnt_q <= dwell_rld_q;
                            state       <= ST_LOAD;
`else
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= ST_DONE;
`endif
                        end else begin
                            inc_q       <= step_next;
                            dwell_cnt_q <= dwell_rld_q;
                            if (idx_q != '1) idx_q <= idx_q + 1'b1;
                            state       <= ST_DWELL;
                        end
                    end else begin
                        dwell_cnt_q <= dwell_cnt_q - 1'b1;
                        state       <= ST_DWELL;
                    end
                end
                ST_DONE: begin
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign O_init_phase   = init_q;
    assign O_change_phase = change_q;
    assign O_inc_phase    = inc_q;
    assign O_busy         = busy_q;
    assign O_done         = done_q;
    assign O_step_idx     = idx_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: directed corner cases plus randomized sweeps
// compared against a list-of-values sweep model.
module tb_dds_sweep_ctrl;

    localparam int Q   = 14;
    localparam int DW  = 16;
    localparam int IW  = 12;
    localparam int MAXI = 2047;

    logic          I_clk = 1'b0;
    logic          I_rst;
    logic          I_start;
    logic          I_abort;
    logic [Q-1:0]  I_init_phase;
    logic [Q-1:0]  I_start_inc;
    logic [Q-1:0]  I_stop_inc;
    logic [Q-1:0]  I_delta_inc;
    logic [DW-1:0] I_dwell;
    logic [Q-1:0]  O_init_phase;
    logic          O_change_phase;
    logic [Q-1:0]  O_inc_phase;
    logic          O_busy;
    logic          O_done;
    logic [IW-1:0] O_step_idx;

    int checks   = 0;
    int failures = 0;

    always #5 I_clk = ~I_clk;

    dds_sweep_ctrl dut (
        .I_clk          (I_clk),
        .I_rst          (I_rst),
        .I_start        (I_start),
        .I_abort        (I_abort),
        .I_init_phase   (I_init_phase),
        .I_start_inc    (I_start_inc),
        .I_stop_inc     (I_stop_inc),
        .I_delta_inc    (I_delta_inc),
        .I_dwell        (I_dwell),
        .O_init_phase   (O_init_phase),
        .O_change_phase (O_change_phase),
        .O_inc_phase    (O_inc_phase),
        .O_busy         (O_busy),
        .O_done         (O_done),
        .O_step_idx     (O_step_idx)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int ch, input int inc, input int idx,
                           input int busy, input int done, input int init);
        chk({tag, ".change"}, 32'(O_change_phase), ch);
        chk({tag, ".inc"},    32'(O_inc_phase),    inc);
        chk({tag, ".idx"},    32'(O_step_idx),     idx);
        chk({tag, ".busy"},   32'(O_busy),         busy);
        chk({tag, ".done"},   32'(O_done),         done);
        chk({tag, ".init"},   32'(O_init_phase),   init);
    endtask

    function automatic int sat(input int v);
        return (v > MAXI) ? MAXI : v;
    endfunction

    // Sweep model: the list of increment values the core should see, in order.
    task automatic build_seq(input int s, input int e, input int d, output int q[$]);
        int v;
        q = {};
        v = s;
        forever begin
            q.push_back(v);
            if (v == e || d == 0) break;
            if (e >= s) v = (v + d >= e) ? e : v + d;
            else        v = (v - d <= e) ? e : v - d;
        end
    endtask

    task automatic step();
        @(posedge I_clk);
        #1;
    endtask

    task automatic kick(input int s, input int e, input int d, input int dw, input int ini,
                        input logic with_abort);
        @(negedge I_clk);
        I_start_inc  = Q'(s);
        I_stop_inc   = Q'(e);
        I_delta_inc  = Q'(d);
        I_dwell      = DW'(dw);
        I_init_phase = Q'(ini);
        I_start      = 1'b1;
        I_abort      = with_abort;
        step();
        I_start = 1'b0;
        I_abort = 1'b0;
    endtask

    // Runs a complete sweep (two periods then abort in loop builds) and checks every cycle.
    task automatic run_sweep(input string tag, input int s_raw, input int e_raw, input int d,
                             input int dw, input int ini);
        int seq[$];
        int dd, n, len, p, last;
        build_seq(sat(s_raw), sat(e_raw), d, seq);
        dd   = (dw == 0) ? 1 : dw;
        n    = seq.size();
        len  = n * dd;
        last = seq[n-1];
        kick(s_raw, e_raw, d, dw, ini, 1'b0);
`ifdef SWEEP_LOOP_EN
        for (int k = 1; k <= 2 * len; k++) begin
            p = (k - 1) % len;
            chk_all(tag, int'(p == 0), seq[p / dd], p / dd, 1, int'(k > len && p == 0), ini);
            step();
        end
        chk_all({tag, ".reload"}, 1, seq[0], 0, 1, 1, ini);
        I_abort = 1'b1;
        step();
        I_abort = 1'b0;
        chk({tag, ".abort_busy"}, 32'(O_busy), 0);
        chk({tag, ".abort_done"}, 32'(O_done), 0);
        chk({tag, ".abort_inc"},  32'(O_inc_phase), seq[0]);
        step();
`else
        for (int k = 1; k <= len; k++) begin
            p = k - 1;
            chk_all(tag, int'(p == 0), seq[p / dd], p / dd, 1, 0, ini);
            step();
        end
        chk_all({tag, ".done"}, 0, last, n - 1, 0, 1, ini);
        step();
        chk_all({tag, ".idle"}, 0, last, n - 1, 0, 0, ini);
`endif
    endtask

    initial begin
        int s, e, d, dw, ini;
        I_rst = 1'b1; I_start = 1'b0; I_abort = 1'b0;
        I_init_phase = '0; I_start_inc = '0; I_stop_inc = '0; I_delta_inc = '0; I_dwell = '0;
        step();
        step();
        chk_all("reset", 0, 0, 0, 0, 0, 0);
        @(negedge I_clk);
        I_rst = 1'b0;
        step();

        run_sweep("basic",    100,  400, 100, 3, 55);
        run_sweep("clamp",    100,  350, 100, 2, 7);
        run_sweep("down",     500,  200, 150, 1, 300);
        run_sweep("dwell0",   100,  400, 100, 0, 12);
        run_sweep("delta0",   100,  400,   0, 2, 99);
        run_sweep("satdown", 3000, 1500, 300, 1, 1);
        run_sweep("satup",   1900, 3000, 100, 2, 2);
        run_sweep("equal",    700,  700,  50, 2, 3);

        // Abort on the fifth busy cycle of the basic sweep.
        kick(100, 400, 100, 3, 77, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            chk_all("pre_abort", int'(k == 1), (k <= 3) ? 100 : 200, (k <= 3) ? 0 : 1, 1, 0, 77);
            if (k < 5) step();
        end
        I_abort = 1'b1;
        step();
        I_abort = 1'b0;
        chk_all("abort", 0, 200, 1, 0, 0, 77);
        for (int k = 0; k < 15; k++) begin
            step();
            chk("abort_nodone", 32'(O_done), 0);
            chk("abort_inc",    32'(O_inc_phase), 200);
        end

        // Start and abort together: nothing may start.
        kick(600, 900, 100, 2, 5, 1'b1);
        for (int k = 0; k < 5; k++) begin
            chk("startabort_busy",   32'(O_busy), 0);
            chk("startabort_change", 32'(O_change_phase), 0);
            chk("startabort_inc",    32'(O_inc_phase), 200);
            step();
        end

        // Synchronous reset during DWELL, then a normal sweep.
        kick(100, 400, 100, 3, 44, 1'b0);
        repeat (5) step();
        chk("pre_reset_busy", 32'(O_busy), 1);
        I_rst = 1'b1;
        step();
        I_rst = 1'b0;
        chk_all("midreset", 0, 0, 0, 0, 0, 0);
        step();
        run_sweep("after_reset", 100, 400, 100, 3, 66);

        for (int r = 0; r < 14; r++) begin
            s   = (r % 4 == 0) ? $urandom_range(16383, 0) : $urandom_range(2400, 0);
            e   = $urandom_range(2400, 0);
            d   = (r % 5 == 3) ? 0 : $urandom_range(700, 30);
            dw  = $urandom_range(3, 0);
            ini = $urandom_range(16383, 0);
            run_sweep("rand", s, e, d, dw, ini);
            repeat ($urandom_range(3, 0)) step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
